// File: rtl/mux3_arbiter.sv
// Round-robin arbiter for three requesters sharing a 3:1 mux; registered grant, select and data.
// Define MUX3ARB_TIMEOUT_EN to force a grant hand-off after HOLD_MAX cycles when others wait.
module mux3_arbiter #(
    parameter int unsigned W        = 1,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   req,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    output logic [2:0]   gnt,
    output logic         s0,
    output logic         s1,
    output logic [W-1:0] f,
    output logic         valid
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [2:0]   gnt_d;
    logic         s0_d, s1_d, valid_d;
    logic [W-1:0] f_d;

    logic [2:0]   req_srch;
    logic [1:0]   ord1, ord2, win;
    logic         found, keep, expire, new_grant;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef MUX3ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Only hand off on expiry when someone else is actually waiting.
    assign expire = (state_q == StGrant) && (cnt_q == 8'(HOLD_MAX)) && |(req & ~gnt);
`else
    logic [7:0] unused_hold;

    assign unused_hold = 8'(HOLD_MAX);
    assign expire      = 1'b0;
`endif

    // On expiry the owner is excluded so the search lands on a waiting requester.
    assign req_srch = expire ? (req & ~gnt) : req;
    assign keep     = (state_q == StGrant) && req[ptr_q] && !expire;

    always_comb begin
        ord1  = inc3(ptr_q);
        ord2  = inc3(ord1);
        found = 1'b0;
        win   = ptr_q;
        if (req_srch[ord1]) begin
            found = 1'b1;
            win   = ord1;
        end else if (req_srch[ord2]) begin
            found = 1'b1;
            win   = ord2;
        end else if (req_srch[ptr_q]) begin
            found = 1'b1;
            win   = ptr_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt;
        new_grant = 1'b0;
        if (keep) begin
            state_d = StGrant;
        end else if (found) begin
            state_d   = StGrant;
            ptr_d     = win;
            gnt_d     = 3'b001 << win;
            new_grant = 1'b1;
        end else begin
            state_d = StIdle;
            gnt_d   = 3'b000;
        end
        s1_d = gnt_d[2];
        s0_d = gnt_d[1];
    end

    // Data path follows the currently registered select, so it lags the grant by one cycle.
    always_comb begin
        valid_d = |gnt;
        f_d     = '0;
        if (valid_d) begin
            unique case ({s1, s0})
                2'b00:   f_d = x1;
                2'b01:   f_d = x2;
                2'b10:   f_d = x3;
                default: f_d = '0;
            endcase
        end
    end

`ifdef MUX3ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = 8'd1;
        end else if (state_d == StIdle) begin
            cnt_d = 8'd0;
        end else if (cnt_q < 8'(HOLD_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd2;
            gnt     <= 3'b000;
            s0      <= 1'b0;
            s1      <= 1'b0;
            f       <= '0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            s0      <= s0_d;
            s1      <= s1_d;
            f       <= f_d;
            valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed self-checking bench for mux3_arbiter (W=4, HOLD_MAX=4).
module tb_mux3_arbiter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [W-1:0] x1, x2, x3;
    logic [2:0]   gnt;
    logic         s0, s1;
    logic [W-1:0] f;
    logic         valid;

    int n_cmp = 0;
    int n_err = 0;

    mux3_arbiter #(
        .W        (W),
        .HOLD_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .gnt   (gnt),
        .s0    (s0),
        .s1    (s1),
        .f     (f),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 3'b000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        step();
        step();
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_err++;
            $display("FAIL reset_gnt: got %b want 000", gnt);
        end
        n_cmp++;
        if ({s1, s0} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_sel: got %b want 00", {s1, s0});
        end
        n_cmp++;
        if ({valid, f} !== 5'h00) begin
            n_err++;
            $display("FAIL reset_data: got valid=%b f=%h want 0/0", valid, f);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({gnt, s1, s0, valid} !== 6'b001_00_0) begin
            n_err++;
            $display("FAIL reset_first_grant: got gnt=%b sel=%b v=%b want 001/00/0",
                     gnt, {s1, s0}, valid);
        end
        step();
        n_cmp++;
        if ({valid, f} !== {1'b1, 4'h3}) begin
            n_err++;
            $display("FAIL reset_first_data: got valid=%b f=%h want 1/3", valid, f);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b100;
        step();
        n_cmp++;
        if ({gnt, s1, s0, valid} !== 6'b100_10_0) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b sel=%b v=%b want 100/10/0",
                     gnt, {s1, s0}, valid);
        end
        step();
        n_cmp++;
        if ({valid, f} !== {1'b1, 4'hA}) begin
            n_err++;
            $display("FAIL single_data: got valid=%b f=%h want 1/a", valid, f);
        end
        req = 3'b000;
        step();
        n_cmp++;
        if ({gnt, s1, s0, valid, f} !== {3'b000, 2'b00, 1'b1, 4'hA}) begin
            n_err++;
            $display("FAIL single_release: got gnt=%b sel=%b v=%b f=%h want 000/00/1/a",
                     gnt, {s1, s0}, valid, f);
        end
        step();
        n_cmp++;
        if ({valid, f} !== 5'h00) begin
            n_err++;
            $display("FAIL single_release_data: got valid=%b f=%h want 0/0", valid, f);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp [4];
        exp[0] = 3'b001;
        exp[1] = 3'b010;
        exp[2] = 3'b100;
        exp[3] = 3'b001;
        do_reset();
        req = 3'b111;
        step();
        step();
        n_cmp++;
        if (gnt !== exp[0]) begin
            n_err++;
            $display("FAIL rr_first: got %b want %b", gnt, exp[0]);
        end
        for (int k = 1; k < 4; k++) begin
            req = 3'b111 & ~exp[k-1];
            step();
            n_cmp++;
            if (gnt !== exp[k]) begin
                n_err++;
                $display("FAIL rr_handoff_%0d: got %b want %b", k, gnt, exp[k]);
            end
            req = 3'b111;
            step();
            n_cmp++;
            if (gnt !== exp[k]) begin
                n_err++;
                $display("FAIL rr_hold_%0d: got %b want %b", k, gnt, exp[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 3'b001;
        step();
        req = 3'b100;
        step();
        n_cmp++;
        if ({gnt, s1, s0} !== 5'b100_10) begin
            n_err++;
            $display("FAIL simul_grant: got gnt=%b sel=%b want 100/10", gnt, {s1, s0});
        end
        step();
        n_cmp++;
        if ({valid, f} !== {1'b1, 4'hA}) begin
            n_err++;
            $display("FAIL simul_data: got valid=%b f=%h want 1/a", valid, f);
        end
    endtask

`ifdef MUX3ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [2:0] e;
        do_reset();
        req = 3'b011;
        for (int c = 0; c < 12; c++) begin
            step();
            e = (((c / 4) % 2) == 0) ? 3'b001 : 3'b010;
            n_cmp++;
            if (gnt !== e) begin
                n_err++;
                $display("FAIL timeout_cycle_%0d: got %b want %b", c, gnt, e);
            end
        end
        req = 3'b001;
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (gnt !== 3'b001) begin
                n_err++;
                $display("FAIL timeout_sat_%0d: got %b want 001", c, gnt);
            end
        end
    endtask
`else
    task automatic test_hold();
        do_reset();
        req = 3'b011;
        for (int c = 0; c < 12; c++) begin
            step();
            n_cmp++;
            if (gnt !== 3'b001) begin
                n_err++;
                $display("FAIL hold_cycle_%0d: got %b want 001", c, gnt);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        req = 3'b010;
        step();
        n_cmp++;
        if ({gnt, s1, s0} !== 5'b010_01) begin
            n_err++;
            $display("FAIL mid_grant: got gnt=%b sel=%b want 010/01", gnt, {s1, s0});
        end
        step();
        n_cmp++;
        if ({valid, f} !== {1'b1, 4'h5}) begin
            n_err++;
            $display("FAIL mid_data: got valid=%b f=%h want 1/5", valid, f);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, s1, s0, valid, f} !== 10'd0) begin
            n_err++;
            $display("FAIL mid_async_clear: got gnt=%b sel=%b v=%b f=%h want all 0",
                     gnt, {s1, s0}, valid, f);
        end
        req = 3'b110;
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_err++;
            $display("FAIL mid_restart: got %b want 010", gnt);
        end
    endtask

    initial begin
        x1    = 4'h3;
        x2    = 4'h5;
        x3    = 4'hA;
        req   = 3'b000;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_simultaneous();
`ifdef MUX3ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
